// File: rtl/fib_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fib_control_unit
//  Purpose  : Sequencer for a 16-bit Fibonacci datapath. Captures the index N,
//             clears the datapath work registers, seeds F(1)/F(0), runs the
//             adder N-1 times and loads F(N) into the datapath output
//             register. Provides a start/busy/done handshake upstream and
//             rejects indices whose result would not fit in 16 bits.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_W          width of count_to / count (matches datapath counter)
//    MAX_N        largest index accepted (F(24)=46368 fits in 16 bits)
//  Ports
//    clk          in   1    system clock, rising edge
//    usr_reset    in   1    synchronous active-high reset of this controller
//    start        in   1    request a computation, sampled only in IDLE
//    count_to     in   N_W  N as held in the datapath input register
//    count        in   N_W  datapath iteration counter
//    load_input   out  1    capture N into the datapath input register
//    cu_reset     out  1    active-low clear of datapath counter/current/prev
//    first_time   out  1    seed select: current<=1, prev<=0
//    counter_enb  out  1    advance counter (and adder registers)
//    load_output  out  1    copy current into the datapath output register
//    busy         out  1    computation in progress
//    done         out  1    one-cycle pulse, result valid from this cycle
//    err          out  1    one-cycle pulse, N > MAX_N rejected
// ============================================================================
module fib_control_unit #(
  parameter int N_W   = 5,
  parameter int MAX_N = 24
) (
  input  logic           clk,
  input  logic           usr_reset,
  input  logic           start,
  input  logic [N_W-1:0] count_to,
  input  logic [N_W-1:0] count,
  output logic           load_input,
  output logic           cu_reset,
  output logic           first_time,
  output logic           counter_enb,
  output logic           load_output,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_ITER = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);
  localparam logic [N_W-1:0] ONE_V   = N_W'(1);

  state_t state;
  state_t state_next;

  // Classification of the captured index, all unsigned on N_W bits.
  logic n_too_big;
  logic n_is_zero;
  logic n_is_one;
  logic iter_last;

  assign n_too_big = (count_to > MAX_N_V);
  assign n_is_zero = (count_to == '0);
  assign n_is_one  = (count_to == ONE_V);
  // Only consulted in ITER, where count_to >= 2, so the subtraction never
  // wraps. Matching count_to-1 means this edge brings the counter to N.
  assign iter_last = (count == (count_to - ONE_V));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (usr_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and output decode. All strobes are Moore outputs of the state
  // except load_input, which follows start while idle so that N is captured
  // on the same edge that accepts the request.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    load_input  = 1'b0;
    cu_reset    = 1'b1;
    first_time  = 1'b0;
    counter_enb = 1'b0;
    load_output = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (state)
      S_IDLE: begin
        // Reset overrides the request: no capture while usr_reset is high.
        load_input = start & ~usr_reset;
        if (start) begin
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        // Datapath counter/current/prev cleared on this edge.
        busy     = 1'b1;
        cu_reset = 1'b0;
        if (n_too_big) begin
          state_next = S_ERR;
        end else if (n_is_zero) begin
          // current is already 0 = F(0); go straight to the output load.
          state_next = S_OUT;
        end else begin
          state_next = S_INIT;
        end
      end

      S_INIT: begin
        // Seed current=F(1), prev=F(0); counter becomes 1.
        busy        = 1'b1;
        first_time  = 1'b1;
        counter_enb = 1'b1;
        if (n_is_one) begin
          state_next = S_OUT;
        end else begin
          state_next = S_ITER;
        end
      end

      S_ITER: begin
        busy        = 1'b1;
        counter_enb = 1'b1;
        if (iter_last) begin
          state_next = S_OUT;
        end
      end

      S_OUT: begin
        busy        = 1'b1;
        load_output = 1'b1;
        state_next  = S_DONE;
      end

      S_DONE: begin
        // start is deliberately not looked at here: one request per IDLE.
        done       = 1'b1;
        state_next = S_IDLE;
      end

      S_ERR: begin
        err        = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fib_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fib_control_unit
//  Purpose  : Self-checking bench for fib_control_unit with a behavioural
//             datapath around it and a Fibonacci reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fib_control_unit;

  localparam int N_W   = 5;
  localparam int MAX_N = 24;

  logic           clk = 1'b0;
  logic           usr_reset;
  logic           start;
  logic [N_W-1:0] count_to;
  logic [N_W-1:0] count;
  logic           load_input;
  logic           cu_reset;
  logic           first_time;
  logic           counter_enb;
  logic           load_output;
  logic           busy;
  logic           done;
  logic           err;

  // Behavioural datapath
  logic [N_W-1:0] number_in = '0;
  logic [N_W-1:0] in_reg    = '0;
  logic [N_W-1:0] cnt       = '0;
  logic [15:0]    cur       = '0;
  logic [15:0]    prv       = '0;
  logic [15:0]    nth_fib   = '0;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_nth = '0;

  always #5 clk = ~clk;

  assign count_to = in_reg;
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (load_input) in_reg <= number_in;
    if (!cu_reset) begin
      cnt <= '0;
      cur <= '0;
      prv <= '0;
    end else if (counter_enb) begin
      cnt <= cnt + 1'b1;
      if (first_time) begin
        cur <= 16'd1;
        prv <= 16'd0;
      end else begin
        cur <= cur + prv;
        prv <= cur;
      end
    end
    if (load_output) nth_fib <= cur;
  end

  fib_control_unit #(.N_W(N_W), .MAX_N(MAX_N)) dut (
    .clk         (clk),
    .usr_reset   (usr_reset),
    .start       (start),
    .count_to    (count_to),
    .count       (count),
    .load_input  (load_input),
    .cu_reset    (cu_reset),
    .first_time  (first_time),
    .counter_enb (counter_enb),
    .load_output (load_output),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  function automatic logic [15:0] fib(input int n);
    int a = 0;
    int b = 1;
    for (int i = 0; i < n; i++) begin
      int t = a + b;
      a = b;
      b = t;
    end
    return 16'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_load_input"},  32'(load_input),  0);
    check({tag, "_cu_reset"},    32'(cu_reset),    1);
    check({tag, "_first_time"},  32'(first_time),  0);
    check({tag, "_counter_enb"}, 32'(counter_enb), 0);
    check({tag, "_load_output"}, 32'(load_output), 0);
    check({tag, "_busy"},        32'(busy),        0);
    check({tag, "_done"},        32'(done),        0);
    check({tag, "_err"},         32'(err),         0);
  endtask

  // One request of index n. poke_at>0 re-pulses start after that edge.
  task automatic do_run(input int n, input int poke_at);
    bit   ok       = (n <= MAX_N);
    int   lat_exp  = ok ? ((n == 0) ? 3 : n + 3) : 2;
    int   win      = lat_exp + 4;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   done_e   = -1;
    int   err_e    = -1;
    int   enb_cnt  = 0;
    int   busy_cnt = 0;
    bit   excl_ok  = 1'b1;
    bit   cur_ok   = 1'b1;
    @(negedge clk);
    number_in = N_W'(n);
    start     = 1'b1;
    #1;
    check($sformatf("n%0d_load_input", n), 32'(load_input), 1);
    for (int e = 1; e <= win; e++) begin
      @(negedge clk);
      if (done) begin done_cnt++; if (done_e < 0) done_e = e; end
      if (err)  begin err_cnt++;  if (err_e  < 0) err_e  = e; end
      if (counter_enb) enb_cnt++;
      if (busy) busy_cnt++;
      if ((32'(first_time) + 32'(load_output) + 32'(load_input)) > 1) excl_ok = 1'b0;
      if (cu_reset !== (e != 1)) cur_ok = 1'b0;
      start = (e == poke_at);
    end
    start = 1'b0;
    if (ok) exp_nth = fib(n);
    check($sformatf("n%0d_done_cnt", n), done_cnt, ok ? 1 : 0);
    check($sformatf("n%0d_err_cnt", n), err_cnt, ok ? 0 : 1);
    if (ok) check($sformatf("n%0d_done_edge", n), done_e, lat_exp);
    else    check($sformatf("n%0d_err_edge", n), err_e, 2);
    check($sformatf("n%0d_nth_fib", n), 32'(nth_fib), 32'(exp_nth));
    check($sformatf("n%0d_counter_enb_cycles", n), enb_cnt, ok ? n : 0);
    check($sformatf("n%0d_busy_cycles", n), busy_cnt, lat_exp - 1);
    check($sformatf("n%0d_exclusive", n), 32'(excl_ok), 1);
    check($sformatf("n%0d_cu_reset_only_load", n), 32'(cur_ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    int d_first;
    int d_second;
    logic [15:0] held;

    usr_reset = 1'b1;
    start     = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    usr_reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // Directed indices including both ends of the accepted range and rejects.
    do_run(0, 0);
    do_run(1, 0);
    do_run(2, 0);
    do_run(10, 0);
    do_run(24, 0);
    do_run(25, 0);
    do_run(31, 0);

    // Start re-pulsed during ITER must be ignored.
    do_run(10, 5);

    // Reset in the middle of ITER for N=20.
    held = nth_fib;
    @(negedge clk);
    number_in = 5'd20;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before_reset", 32'(busy), 1);
    usr_reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    usr_reset = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (done || err) done_cnt++;
    end
    check("mid_reset_no_done", done_cnt, 0);
    check("mid_reset_nth_kept", 32'(nth_fib), 32'(held));
    do_run(5, 0);

    // start held high: back-to-back runs separated by one IDLE cycle.
    @(negedge clk);
    number_in = 5'd3;
    start     = 1'b1;
    done_cnt  = 0;
    d_first   = -1;
    d_second  = -1;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (d_first < 0) d_first = e;
        else if (d_second < 0) d_second = e;
      end
      if (e == 7) check("b2b_load_input_in_idle", 32'(load_input), 1);
      if (e == 13) start = 1'b0;
    end
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_first_done", d_first, 6);
    check("b2b_second_done", d_second, 13);
    exp_nth = fib(3);
    check("b2b_nth_fib", 32'(nth_fib), 32'(exp_nth));

    // Random indices over the full N_W range.
    for (int i = 0; i < 12; i++) begin
      do_run(int'($urandom_range(0, 31)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
